// File: rtl/up_down_count_monitor_if.sv
// Sample/status bundle between an up/down counter probe and its monitor.
// Optional wrap counter signal exists only with COUNT_MON_WRAP_CNT_EN defined.
interface up_down_count_monitor_if #(
  parameter int unsigned WIDTH = 3
);

  localparam int unsigned CNT_W = 8;

  logic             valid;
  logic [WIDTH-1:0] Q_in;
  logic             locked;
  logic             dir;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
`ifdef COUNT_MON_WRAP_CNT_EN
  logic [CNT_W-1:0] wrap_cnt;
`endif

  // Sample source: drives samples, observes monitor status.
  modport master (
    output valid,
    output Q_in,
    input  locked,
    input  dir,
    input  err,
    input  err_cnt
`ifdef COUNT_MON_WRAP_CNT_EN
    , input wrap_cnt
`endif
  );

  // Monitor: consumes samples, produces status.
  modport slave (
    input  valid,
    input  Q_in,
    output locked,
    output dir,
    output err,
    output err_cnt
`ifdef COUNT_MON_WRAP_CNT_EN
    , output wrap_cnt
`endif
  );

endinterface

// File: rtl/up_down_count_monitor.sv
// Watches the output of an up/down counter and checks that consecutive valid
// samples step by +1, -1 or stall (mod 2^WIDTH) once a direction is locked.
// Optional feature: define COUNT_MON_WRAP_CNT_EN to add the wrap_cnt counter.
// WIDTH must be >= 2 so that +1 and -1 are distinguishable.
module up_down_count_monitor #(
  parameter int unsigned WIDTH = 3
) (
  input logic                    clk,
  input logic                    clear_n,
  up_down_count_monitor_if.slave mon
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SYNC      = 2'd1,
    LOCK_UP   = 2'd2,
    LOCK_DOWN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             locked_q, locked_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] prev_inc_c;
  logic [WIDTH-1:0] prev_dec_c;
  logic             is_inc_c;
  logic             is_dec_c;
  logic             is_same_c;
  logic             seq_err_c;

  // Neighbours of the previous sample; the natural WIDTH-bit wrap gives mod 2^WIDTH.
  assign prev_inc_c = prev_q + WIDTH'(1);
  assign prev_dec_c = prev_q - WIDTH'(1);
  assign is_inc_c   = (mon.Q_in == prev_inc_c);
  assign is_dec_c   = (mon.Q_in == prev_dec_c);
  assign is_same_c  = (mon.Q_in == prev_q);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      locked_q  <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      locked_q  <= locked_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and next-output decode; idle cycles hold everything but err.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    dir_d     = dir_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    seq_err_c = 1'b0;

    if (mon.valid) begin
      prev_d = mon.Q_in;
      case (state_q)
        IDLE: begin
          state_d = SYNC;
        end
        SYNC: begin
          if (is_inc_c) begin
            state_d = LOCK_UP;
          end else if (is_dec_c) begin
            state_d = LOCK_DOWN;
          end
        end
        LOCK_UP: begin
          if (is_inc_c || is_same_c) begin
            state_d = LOCK_UP;
          end else if (is_dec_c) begin
            state_d = LOCK_DOWN;
          end else begin
            state_d   = SYNC;
            seq_err_c = 1'b1;
          end
        end
        LOCK_DOWN: begin
          if (is_dec_c || is_same_c) begin
            state_d = LOCK_DOWN;
          end else if (is_inc_c) begin
            state_d = LOCK_UP;
          end else begin
            state_d   = SYNC;
            seq_err_c = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    err_d = seq_err_c;
    if (seq_err_c && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    locked_d = (state_d == LOCK_UP) || (state_d == LOCK_DOWN);
    if (state_d == LOCK_UP) begin
      dir_d = 1'b0;
    end else if (state_d == LOCK_DOWN) begin
      dir_d = 1'b1;
    end
  end

  assign mon.locked  = locked_q;
  assign mon.dir     = dir_q;
  assign mon.err     = err_q;
  assign mon.err_cnt = err_cnt_q;

`ifdef COUNT_MON_WRAP_CNT_EN
  localparam logic [WIDTH-1:0] Q_MAX = '1;

  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             wrap_c;

  // In-sequence wrap while locked: max->0 going up, 0->max going down.
  always_comb begin
    wrap_c = 1'b0;
    if (mon.valid) begin
      if ((state_q == LOCK_UP) && (prev_q == Q_MAX) && (mon.Q_in == '0)) begin
        wrap_c = 1'b1;
      end else if ((state_q == LOCK_DOWN) && (prev_q == '0) && (mon.Q_in == Q_MAX)) begin
        wrap_c = 1'b1;
      end
    end
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_c && (wrap_cnt_q != CNT_MAX)) begin
      wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
    end
  end

  // Saturating wrap counter register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign mon.wrap_cnt = wrap_cnt_q;
`endif

endmodule
